// File: rtl/sweep_sequencer.sv
`timescale 1ns/1ps
// sweep_sequencer: drives a six-bit up/down counter through paced ping-pong
// sweeps (0 -> 63 -> 0), dwelling at each end, for a fixed number of sweeps
// or continuously until stopped.
module sweep_sequencer #(
  parameter int TICK_DIV    = 4,  // clk cycles per counter step, >= 2
  parameter int PAUSE_TICKS = 8,  // ticks of dwell at each end
  parameter int SWEEP_W     = 4   // width of sweeps / sweep_cnt
) (
  input  logic               clk,
  input  logic               reset,        // asynchronous, active-low
  input  logic               start,
  input  logic               stop,
  input  logic               mode_loop,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic [5:0]         cnt_value,
  input  logic               cnt_finish,
  output logic               cnt_enable,
  output logic               cnt_forward,
  output logic               cnt_reset,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PW = $clog2(PAUSE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, RUN_FWD, PAUSE_TOP, RUN_BWD, PAUSE_BOT, DONE
  } state_t;

  state_t             state, state_nx;
  logic [TW-1:0]      tick_cnt, tick_cnt_nx;
  logic [PW-1:0]      pause_cnt, pause_cnt_nx;
  logic [SWEEP_W-1:0] sweeps_q, sweeps_nx;
  logic [SWEEP_W-1:0] sweep_cnt_nx, sweep_inc;
  logic               loop_q, loop_nx;
  logic               enable_nx, forward_nx, reset_nx, busy_nx, done_nx;
  logic               timed, paused, tick;

  // The counter value is observed for monitoring only; the finish flag alone
  // steers the sequence.
  logic unused_value;
  assign unused_value = ^cnt_value;

  assign timed     = state inside {RUN_FWD, PAUSE_TOP, RUN_BWD, PAUSE_BOT};
  assign paused    = state inside {PAUSE_TOP, PAUSE_BOT};
  assign tick      = timed && (tick_cnt == TICK_LAST);
  assign sweep_inc = sweep_cnt + 1'b1;

  // Next-state, next-output and counter update logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_nx     = state;
    sweeps_nx    = sweeps_q;
    loop_nx      = loop_q;
    sweep_cnt_nx = sweep_cnt;
    enable_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx     = CLEAR;
          sweeps_nx    = (sweeps == '0) ? SWEEP_W'(1) : sweeps;
          loop_nx      = mode_loop;
          sweep_cnt_nx = '0;
        end
      end
      CLEAR: state_nx = RUN_FWD;
      RUN_FWD: begin
        // Finish wins over a coincident tick so the counter never overshoots.
        if (cnt_finish) state_nx  = PAUSE_TOP;
        else            enable_nx = tick;
      end
      PAUSE_TOP: begin
        if (tick && pause_cnt == PAUSE_LAST) state_nx = RUN_BWD;
      end
      RUN_BWD: begin
        if (cnt_finish) begin
          sweep_cnt_nx = sweep_inc;
          if (!loop_q && sweep_inc == sweeps_q) state_nx = DONE;
          else                                  state_nx = PAUSE_BOT;
        end else begin
          enable_nx = tick;
        end
      end
      PAUSE_BOT: begin
        if (tick && pause_cnt == PAUSE_LAST) state_nx = RUN_FWD;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Abort from any active state: no step, no done, sweep count kept.
    if (stop && state != IDLE) begin
      state_nx     = IDLE;
      enable_nx    = 1'b0;
      sweep_cnt_nx = sweep_cnt;
    end

    reset_nx   = (state_nx == CLEAR);
    done_nx    = (state_nx == DONE);
    busy_nx    = !(state_nx inside {IDLE, DONE});
    forward_nx = !(state_nx inside {RUN_BWD, PAUSE_BOT});

    // Prescaler and dwell counter restart on every state change.
    if (state_nx != state || !timed) tick_cnt_nx = '0;
    else if (tick)                   tick_cnt_nx = '0;
    else                             tick_cnt_nx = tick_cnt + 1'b1;

    if (state_nx != state)  pause_cnt_nx = '0;
    else if (paused && tick) pause_cnt_nx = pause_cnt + 1'b1;
    else                     pause_cnt_nx = pause_cnt;
  end

  // State, timing counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      pause_cnt   <= '0;
      sweeps_q    <= '0;
      loop_q      <= 1'b0;
      sweep_cnt   <= '0;
      cnt_enable  <= 1'b0;
      cnt_forward <= 1'b1;
      cnt_reset   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      tick_cnt    <= tick_cnt_nx;
      pause_cnt   <= pause_cnt_nx;
      sweeps_q    <= sweeps_nx;
      loop_q      <= loop_nx;
      sweep_cnt   <= sweep_cnt_nx;
      cnt_enable  <= enable_nx;
      cnt_forward <= forward_nx;
      cnt_reset   <= reset_nx;
      busy        <= busy_nx;
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_sweep_sequencer.sv
`timescale 1ns/1ps
// tb_sweep_sequencer: directed bench for sweep_sequencer closed around a
// behavioural model of the six-bit up/down counter.
module tb_sweep_sequencer;

  localparam int TICK_DIV    = 4;
  localparam int PAUSE_TICKS = 8;
  localparam int SWEEP_W     = 4;
  // Last forward step to first backward step: 1 cycle for the counter to
  // reach 63, 1 cycle to leave RUN_FWD, the dwell, then one prescaler period.
  localparam int TURN_GAP    = 2 + PAUSE_TICKS * TICK_DIV + TICK_DIV;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               mode_loop = 1'b0;
  logic [SWEEP_W-1:0] sweeps = '0;
  logic [5:0]         cnt_value = '0;
  logic               cnt_finish;
  logic               cnt_enable, cnt_forward, cnt_reset, busy, done;
  logic [SWEEP_W-1:0] sweep_cnt;

  int errors = 0;
  int checks = 0;

  // Monitor statistics, written only by the monitor process.
  int cyc = 0, en_fwd = 0, en_bwd = 0, rst_pulses = 0, done_pulses = 0;
  int overshoot = 0, gap_std = 0, gap_other = 0, last_gap = 0, last_en_cyc = 0;
  bit last_en_valid = 1'b0;

  // Snapshots taken by the stimulus process.
  int b_fwd, b_bwd, b_rst, b_done, b_std, b_other, b_over;
  bit got;

  sweep_sequencer #(
    .TICK_DIV(TICK_DIV), .PAUSE_TICKS(PAUSE_TICKS), .SWEEP_W(SWEEP_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .mode_loop(mode_loop), .sweeps(sweeps), .cnt_value(cnt_value),
    .cnt_finish(cnt_finish), .cnt_enable(cnt_enable),
    .cnt_forward(cnt_forward), .cnt_reset(cnt_reset), .busy(busy),
    .done(done), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural up/down counter with synchronous clear.
  always @(posedge clk) begin
    if (cnt_reset)       cnt_value <= 6'd0;
    else if (cnt_enable) cnt_value <= cnt_forward ? cnt_value + 6'd1 : cnt_value - 6'd1;
  end
  assign cnt_finish = cnt_forward ? (cnt_value == 6'd63) : (cnt_value == 6'd0);

  // Pulse counters and step spacing, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cnt_reset) begin
      rst_pulses    <= rst_pulses + 1;
      last_en_valid <= 1'b0;
    end
    if (done) done_pulses <= done_pulses + 1;
    if (cnt_enable) begin
      if (cnt_forward) en_fwd <= en_fwd + 1;
      else             en_bwd <= en_bwd + 1;
      if (cnt_finish) overshoot <= overshoot + 1;
      if (last_en_valid) begin
        if (cyc - last_en_cyc == TICK_DIV) gap_std <= gap_std + 1;
        else begin
          gap_other <= gap_other + 1;
          last_gap  <= cyc - last_en_cyc;
        end
      end
      last_en_cyc   <= cyc;
      last_en_valid <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    b_fwd = en_fwd; b_bwd = en_bwd; b_rst = rst_pulses; b_done = done_pulses;
    b_std = gap_std; b_other = gap_other; b_over = overshoot;
  endtask

  task automatic start_run(input logic [SWEEP_W-1:0] n, input logic loop);
    sweeps = n; mode_loop = loop; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check(tag, got, 1);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_enable",  cnt_enable, 0);
    check("rst_forward", cnt_forward, 1);
    check("rst_cnt_reset", cnt_reset, 0);
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_sweep_cnt", sweep_cnt, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Single sweep.
    snapshot();
    start_run(4'd1, 1'b0);
    check("clear_pulse", cnt_reset, 1);
    check("clear_busy",  busy, 1);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (cnt_value == 6'd63) got = 1'b1;
    end
    check("fwd_peak_reached", got, 1);
    check("fwd_pulses_at_peak", en_fwd - b_fwd, 63);
    wait_done(800, "single_done");
    check("single_sweep_cnt", sweep_cnt, 1);
    check("single_busy_at_done", busy, 0);
    check("single_counter_home", cnt_value, 0);
    repeat (3) @(negedge clk);
    check("single_fwd_pulses", en_fwd - b_fwd, 63);
    check("single_bwd_pulses", en_bwd - b_bwd, 63);
    check("single_clear_pulses", rst_pulses - b_rst, 1);
    check("single_done_pulses", done_pulses - b_done, 1);
    check("single_gaps_of_tickdiv", gap_std - b_std, 124);
    check("single_turn_gaps", gap_other - b_other, 1);
    check("single_turn_gap_len", last_gap, TURN_GAP);
    check("single_overshoot", overshoot - b_over, 0);

    // sweeps=0 runs as one sweep.
    snapshot();
    start_run(4'd0, 1'b0);
    wait_done(800, "zero_done");
    check("zero_sweep_cnt", sweep_cnt, 1);
    repeat (3) @(negedge clk);
    check("zero_pulses", (en_fwd - b_fwd) + (en_bwd - b_bwd), 126);
    check("zero_done_pulses", done_pulses - b_done, 1);

    // Three sweeps.
    snapshot();
    start_run(4'd3, 1'b0);
    wait_done(2400, "three_done");
    check("three_sweep_cnt", sweep_cnt, 3);
    repeat (3) @(negedge clk);
    check("three_pulses", (en_fwd - b_fwd) + (en_bwd - b_bwd), 378);
    check("three_done_pulses", done_pulses - b_done, 1);
    check("three_gaps_of_tickdiv", gap_std - b_std, 372);
    check("three_turn_gaps", gap_other - b_other, 5);
    check("three_overshoot", overshoot - b_over, 0);

    // Loop mode; later changes to sweeps/mode_loop must be ignored.
    snapshot();
    start_run(4'd1, 1'b1);
    sweeps = 4'd1; mode_loop = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (sweep_cnt == 4'd5) got = 1'b1;
    end
    check("loop_reached_5", got, 1);
    check("loop_busy", busy, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("loop_stop_busy", busy, 0);
    check("loop_stop_enable", cnt_enable, 0);
    check("loop_stop_sweep_cnt", sweep_cnt, 5);
    repeat (20) @(negedge clk);
    check("loop_no_done", done_pulses - b_done, 0);
    check("loop_held_sweep_cnt", sweep_cnt, 5);
    check("loop_pulses", (en_fwd - b_fwd) + (en_bwd - b_bwd), 5 * 126);

    // start and stop together in IDLE: stop wins.
    snapshot();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("startstop_no_clear", rst_pulses - b_rst, 0);
    check("startstop_idle", busy, 0);

    // start during RUN_BWD is ignored.
    snapshot();
    start_run(4'd1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 800 && !got; i++) begin
      @(negedge clk);
      if (busy && !cnt_forward && cnt_value < 6'd40) got = 1'b1;
    end
    check("bwd_reached", got, 1);
    sweeps = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bwd_start_still_busy", busy, 1);
    check("bwd_start_no_clear", cnt_reset, 0);
    wait_done(800, "bwd_done");
    check("bwd_sweep_cnt", sweep_cnt, 1);
    repeat (3) @(negedge clk);
    check("bwd_clear_pulses", rst_pulses - b_rst, 1);
    check("bwd_pulses", (en_fwd - b_fwd) + (en_bwd - b_bwd), 126);

    // Asynchronous reset while stepping forward.
    start_run(4'd1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (cnt_enable && cnt_value == 6'd20) got = 1'b1;
    end
    check("fwd20_reached", got, 1);
    reset = 1'b0;
    #1;
    check("async_enable", cnt_enable, 0);
    check("async_forward", cnt_forward, 1);
    check("async_busy", busy, 0);
    check("async_sweep_cnt", sweep_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    snapshot();
    repeat (20) @(negedge clk);
    check("post_reset_no_steps", (en_fwd - b_fwd) + (en_bwd - b_bwd), 0);
    check("post_reset_no_clear", rst_pulses - b_rst, 0);
    check("post_reset_counter_kept", cnt_value, 20);
    check("post_reset_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
